// File: rtl/game_tick_scheduler.sv
// Periodic tick shared among NUM_CH countdown channels through one time-shared decrementer, with an Avalon-MM register map.
// Optional tick prescaler at address 12 is built when TICK_SCHED_PRESCALE_EN is defined.
module game_tick_scheduler #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tick_in,
    input  logic [3:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        irq
);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t             state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic               tickPend_q, tickPend_d;
    logic               overrun_q, overrun_d;
    logic [NUM_CH-1:0]  pending_q, pending_d;
    logic [NUM_CH-1:0]  enable_q, enable_d;
    logic [NUM_CH-1:0]  mode_q, mode_d;
    logic [NUM_CH-1:0]  mask_q, mask_d;
    logic [CNT_W-1:0]   reload_q [NUM_CH];
    logic [CNT_W-1:0]   reload_d [NUM_CH];
    logic [CNT_W-1:0]   count_q  [NUM_CH];
    logic [CNT_W-1:0]   count_d  [NUM_CH];
    logic [15:0]        rdata_q, rdata_d;

    logic wrEn;
    logic tickFwd;

    assign wrEn = chipselect & ~write_n;

`ifdef TICK_SCHED_PRESCALE_EN
    logic [7:0] prescale_q, prescale_d;
    logic [7:0] preCnt_q, preCnt_d;

    // A PRESCALE write restarts the divider so the new ratio starts from a clean phase.
    always_comb begin
        prescale_d = prescale_q;
        preCnt_d   = preCnt_q;
        tickFwd    = 1'b0;
        if (tick_in) begin
            if (preCnt_q == prescale_q) begin
                tickFwd  = 1'b1;
                preCnt_d = '0;
            end else begin
                preCnt_d = preCnt_q + 8'd1;
            end
        end
        if (wrEn && address == 4'd12) begin
            prescale_d = writedata[7:0];
            preCnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prescale_q <= '0;
            preCnt_q   <= '0;
        end else begin
            prescale_q <= prescale_d;
            preCnt_q   <= preCnt_d;
        end
    end
`else
    assign tickFwd = tick_in;
`endif

    // CPU writes are applied first; the scan step then overrides where event-set must win.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        tickPend_d = tickPend_q;
        overrun_d  = overrun_q;
        pending_d  = pending_q;
        enable_d   = enable_q;
        mode_d     = mode_q;
        mask_d     = mask_q;
        reload_d   = reload_q;
        count_d    = count_q;

        if (wrEn) begin
            case (address)
                4'd0: begin
                    pending_d = pending_q & ~writedata[NUM_CH-1:0];
                    if (writedata[15]) overrun_d = 1'b0;
                end
                4'd1:    enable_d = writedata[NUM_CH-1:0];
                4'd2:    mode_d   = writedata[NUM_CH-1:0];
                4'd3:    mask_d   = writedata[NUM_CH-1:0];
                default: ;
            endcase
            for (int n = 0; n < NUM_CH; n++) begin
                if (address == 4'(4 + n)) begin
                    reload_d[n] = writedata[CNT_W-1:0];
                    count_d[n]  = writedata[CNT_W-1:0];
                end
            end
        end

        case (state_q)
            IDLE: begin
                if (tickFwd || tickPend_q) begin
                    state_d    = SCAN;
                    idx_d      = '0;
                    tickPend_d = tickPend_q & tickFwd;
                end
            end
            SCAN: begin
                if (tickFwd) begin
                    if (tickPend_q) overrun_d  = 1'b1;
                    else            tickPend_d = 1'b1;
                end
                for (int n = 0; n < NUM_CH; n++) begin
                    if (idx_q == 2'(n) && enable_q[n] && !(wrEn && address == 4'(4 + n))) begin
                        if (count_q[n] == CNT_W'(1)) begin
                            pending_d[n] = 1'b1;
                            if (mode_q[n]) begin
                                count_d[n] = reload_q[n];
                            end else begin
                                count_d[n] = '0;
                                if (!(wrEn && address == 4'd1)) enable_d[n] = 1'b0;
                            end
                        end else if (count_q[n] != '0) begin
                            count_d[n] = count_q[n] - CNT_W'(1);
                        end
                    end
                end
                if (idx_q == 2'(NUM_CH - 1)) state_d = IDLE;
                else                         idx_d   = idx_q + 2'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rdata_d = '0;
        case (address)
            4'd0: begin
                rdata_d[15]         = overrun_q;
                rdata_d[NUM_CH-1:0] = pending_q;
            end
            4'd1: rdata_d[NUM_CH-1:0] = enable_q;
            4'd2: rdata_d[NUM_CH-1:0] = mode_q;
            4'd3: rdata_d[NUM_CH-1:0] = mask_q;
`ifdef TICK_SCHED_PRESCALE_EN
            4'd12: rdata_d[7:0] = prescale_q;
`endif
            default: ;
        endcase
        for (int n = 0; n < NUM_CH; n++) begin
            if (address == 4'(4 + n)) rdata_d = 16'(reload_q[n]);
            if (address == 4'(8 + n)) rdata_d = 16'(count_q[n]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            tickPend_q <= 1'b0;
            overrun_q  <= 1'b0;
            pending_q  <= '0;
            enable_q   <= '0;
            mode_q     <= '0;
            mask_q     <= '0;
            reload_q   <= '{default: '0};
            count_q    <= '{default: '0};
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            tickPend_q <= tickPend_d;
            overrun_q  <= overrun_d;
            pending_q  <= pending_d;
            enable_q   <= enable_d;
            mode_q     <= mode_d;
            mask_q     <= mask_d;
            reload_q   <= reload_d;
            count_q    <= count_d;
            rdata_q    <= rdata_d;
        end
    end

    assign readdata = rdata_q;
    assign irq      = |(pending_q & mask_q);

endmodule
